seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Multi-cycle iterative shifter: accepts a word plus shift controls over a valid/ready input handshake, shifts one bit position per clock, then presents the result over a valid/ready output handshake.
- Sequential counterpart to the team's combinational barrel shifter, with the same control semantics: LR=1 left, LR=0 right; AL=1 arithmetic, AL=0 logical.
- Bit-exact with the barrel shifter for every din/shamt/LR/AL combination. Used where area matters more than latency, and as a cross-check model in the lab bench.

Parameters:
- WIDTH, 8, data width in bits (>=2)
- SHW, 3, shift-amount width; shamt range 0..2^SHW-1 (must be <= WIDTH-1)

Ports:
- clk, input, 1, clock; all state updates on rising edge
- rst_n, input, 1, synchronous active-low reset
- in_valid, input, 1, request carries a valid operand set
- in_ready, output, 1, block can accept a request
- din, input, WIDTH, operand
- shamt, input, SHW, shift amount
- LR, input, 1, direction: 1 = left, 0 = right
- AL, input, 1, 1 = arithmetic right, 0 = logical; ignored for left shifts
- out_valid, output, 1, dout holds the final result
- out_ready, input, 1, consumer accepts the result
- dout, output, WIDTH, working/result register
- busy, output, 1, high in SHIFT or DONE

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, dout=0, count=0, out_valid=0, busy=0, in_ready=1 from the following cycle.
  - Reset wins over any handshake in the same cycle.
  - Reset mid-operation abandons the operation with no partial result delivered.
- FSM states: IDLE, SHIFT, DONE. Outputs decoded from state (Moore):
  - in_ready = (state==IDLE)
  - out_valid = (state==DONE)
  - busy = (state!=IDLE)
- IDLE:
  - On in_valid&&in_ready: capture dout<=din, count<=shamt, dir<=LR, arith<=AL.
  - Next state is DONE if shamt==0, else SHIFT.
  - din/shamt/LR/AL are sampled only at the accept edge; later changes have no effect.
- SHIFT, at each edge:
  - Left: dout<={dout[WIDTH-2:0],1'b0}.
  - Right logical: dout<={1'b0,dout[WIDTH-1:1]}.
  - Right arithmetic: dout<={dout[WIDTH-1],dout[WIDTH-1:1]}.
  - count<=count-1.
  - When count==1 at the edge, move to DONE.
- DONE:
  - dout is held stable while out_valid=1 and out_ready=0 (backpressure of any length).
  - On out_ready=1, move to IDLE.
  - No new request can be accepted in the same cycle as the DONE→IDLE transition (in_ready=0 in DONE).
- Latency, accept edge to first cycle with out_valid=1:
  - shamt+1 cycles for shamt>=1.
  - 1 cycle for shamt==0.
- Throughput: one operation per shamt+2 cycles minimum (shamt==0: 2 cycles).
- dout is visible during SHIFT (intermediate values) but is only defined as the result while out_valid=1.
- in_valid while busy: ignored, not queued.
- out_ready while not DONE: ignored.
- shamt==WIDTH-1 arithmetic right: dout becomes all copies of the sign bit.
- Left shifts never sign-extend.
- count never underflows.

Test Plan:
- Left shift: din=8'b1011_0110, shamt=3, LR=1, AL=0, out_ready=1 → out_valid on the 4th cycle after accept, dout=8'b1011_0000, back to IDLE the next cycle.
- Right logical vs arithmetic: din=8'h96, shamt=2, LR=0 → AL=0 gives dout=8'h25; AL=1 gives dout=8'hE5.
- Arithmetic extremes: shamt=7, LR=0, AL=1 → din=8'h96 gives 8'hFF; din=8'h56 gives 8'h00. AL=1 with LR=1 on din=8'h96, shamt=1 gives 8'h2C.
- shamt=0: din=8'hA5 → out_valid 1 cycle after accept with dout=8'hA5.
- Backpressure and ignored input: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with din=8'hFF → dout stable, in_ready=0 throughout, no second operation starts. Then out_ready=1 → IDLE, and the next request is accepted normally.
- Reset mid-operation: accept din=8'h81, shamt=7. Drive rst_n=0 on cycle 3 of SHIFT → next cycle dout=0, out_valid=0, in_ready=1. A fresh request then completes with the correct result; randomized 1000-op compare against a barrel-shifter reference model passes.

Source files
------------

// File: rtl/seq_shifter.sv
// seq_shifter: iterative shifter moving one bit per clock between valid/ready handshakes
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst_n     - synchronous active-low reset
//   in_valid  - request carries a valid operand set
//   in_ready  - block can accept a request (IDLE)
//   din       - operand
//   shamt     - shift amount
//   LR        - direction: 1 = left, 0 = right
//   AL        - 1 = arithmetic right, 0 = logical; ignored for left shifts
//   out_valid - dout holds the final result (DONE)
//   out_ready - consumer accepts the result
//   dout      - working/result register
//   busy      - high in SHIFT or DONE
module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic             LR,
    input  logic             AL,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             dir_q, dir_d;
    logic             arith_q, arith_d;
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign dout      = dout_q;
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        count_d = count_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        case (state_q)
            IDLE: if (in_valid) begin
                dout_d  = din;
                count_d = shamt;
                dir_d   = LR;
                arith_d = AL;
                state_d = shamt == '0 ? DONE : SHIFT;
            end
            SHIFT: begin
                // arith only matters for right shifts; it selects the fill bit
                dout_d  = dir_q ? {dout_q[WIDTH-2:0], 1'b0}
                                : {arith_q & dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
                count_d = count_q - 1'b1;
                state_d = count_q == SHW'(1) ? DONE : SHIFT;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dout_q  <= '0;
            count_q <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
        end
    end
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: randomized and directed checks of seq_shifter against a barrel-shift model
module tb_seq_shifter;
    localparam int W = 8;
    localparam int S = 3;
    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, lr, al, out_valid, out_ready, busy;
    logic [W-1:0] din, dout;
    logic [S-1:0] shamt;
    int           checks = 0;
    int           errors = 0;

    seq_shifter #(.WIDTH(W), .SHW(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .shamt(shamt), .LR(lr), .AL(al), .out_valid(out_valid),
        .out_ready(out_ready), .dout(dout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s, input logic l, input logic a);
        logic signed [W-1:0] sd;
        sd = d;
        if (l) return d << s;
        if (a) return W'(sd >>> s);
        return d >> s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] d, input logic [S-1:0] s, input logic l, input logic a,
                         input logic [W-1:0] exp, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; din = d; shamt = s; lr = l; al = a;
        step();
        in_valid = 1'b0; din = W'($urandom); shamt = S'($urandom); lr = ~l; al = ~a;
        n = 1;
        while (!out_valid && n < 40) begin
            check("busy_mid", {30'd0, busy, in_ready}, 32'd2);
            step();
            n++;
        end
        check("latency", n, (s == 0) ? 1 : int'(s) + 1);
        check("dout", {24'd0, dout}, {24'd0, exp});
        for (int k = 0; k < hold; k++) begin
            in_valid = k[0] ? 1'b0 : 1'b1;
            din = '1;
            shamt = 3'd1;
            step();
            check("hold_state", {29'd0, out_valid, in_ready, busy}, 32'd5);
            check("hold_dout", {24'd0, dout}, {24'd0, exp});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("back_idle", {29'd0, out_valid, in_ready, busy}, 32'd2);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [S-1:0] s;
        logic         l, a;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0; shamt = '0; lr = 1'b0; al = 1'b0;
        step();
        step();
        check("reset_dout", {24'd0, dout}, 32'd0);
        check("reset_flags", {29'd0, out_valid, in_ready, busy}, 32'd2);
        rst_n = 1'b1;
        do_op(8'b1011_0110, 3'd3, 1'b1, 1'b0, 8'b1011_0000, 0);
        do_op(8'h96, 3'd2, 1'b0, 1'b0, 8'h25, 1);
        do_op(8'h96, 3'd2, 1'b0, 1'b1, 8'hE5, 0);
        do_op(8'h96, 3'd7, 1'b0, 1'b1, 8'hFF, 0);
        do_op(8'h56, 3'd7, 1'b0, 1'b1, 8'h00, 0);
        do_op(8'h96, 3'd1, 1'b1, 1'b1, 8'h2C, 0);
        do_op(8'hA5, 3'd0, 1'b0, 1'b1, 8'hA5, 0);
        do_op(8'h3C, 3'd4, 1'b0, 1'b0, 8'h03, 5);
        do_op(8'h0F, 3'd2, 1'b1, 1'b0, 8'h3C, 0);
        // reset in the third SHIFT cycle abandons the operation
        in_valid = 1'b1; din = 8'h81; shamt = 3'd7; lr = 1'b0; al = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        check("midreset_dout", {24'd0, dout}, 32'd0);
        check("midreset_flags", {29'd0, out_valid, in_ready, busy}, 32'd2);
        do_op(8'h81, 3'd7, 1'b0, 1'b1, 8'hFF, 0);
        for (int i = 0; i < 1000; i++) begin
            d = W'($urandom);
            s = S'($urandom);
            l = 1'($urandom);
            a = 1'($urandom);
            do_op(d, s, l, a, ref_shift(d, int'(s), l, a), $urandom_range(0, 3));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
